// File: rtl/max_pool_engine.sv
// ============================================================================
// max_pool_engine
// ----------------------------------------------------------------------------
// Layer-side responder for the CNN start/done handshake. On start it captures
// a flattened IN_DIM x IN_DIM signed feature map and computes a POOL x POOL,
// stride-POOL max pool. It visits one window element per clock, writes each
// pooled value into a registered output map, and pulses done for one cycle.
//
// Optional build macro:
//   POOL_RELU_EN : when defined, a negative window maximum is stored as 0
//                  (fused ReLU). Timing and handshake are the same either way.
//
// Ports:
//   clk        in   1                       rising-edge clock
//   rst        in   1                       asynchronous reset, active low
//   start      in   1                       run request, sampled in IDLE only
//   input_fm   in   IN_DIM*IN_DIM*DATA_W    element row*IN_DIM+col at
//                                           [i*DATA_W +: DATA_W]
//   busy       out  1                       high in every state except IDLE
//   done       out  1                       one-cycle completion pulse
//   output_fm  out  OUT_DIM^2*DATA_W        pooled map, index r*OUT_DIM+c
// ============================================================================
module max_pool_engine #(
    parameter int DATA_W = 32,
    parameter int IN_DIM = 6,
    parameter int POOL   = 2
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            start,
    input  logic [IN_DIM*IN_DIM*DATA_W-1:0]                 input_fm,
    output logic                                            busy,
    output logic                                            done,
    output logic [(IN_DIM/POOL)*(IN_DIM/POOL)*DATA_W-1:0]   output_fm
);

    localparam int OUT_DIM = IN_DIM / POOL;
    // Counter widths use N+1 so a size-1 dimension still gets a 1-bit counter.
    localparam int PW      = $clog2(POOL + 1);
    localparam int OW      = $clog2(OUT_DIM + 1);

    localparam logic [PW-1:0] POOL_LAST = PW'(POOL - 1);
    localparam logic [OW-1:0] OUT_LAST  = OW'(OUT_DIM - 1);

    generate
        if (IN_DIM % POOL != 0) begin : g_bad_pool
            $error("max_pool_engine: IN_DIM must be divisible by POOL");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [IN_DIM*IN_DIM*DATA_W-1:0] fm_buf;     // map captured in LOAD
    logic [OW-1:0]                   out_r, out_c;
    logic [PW-1:0]                   win_r, win_c;
    logic signed [DATA_W-1:0]        run_max;

    logic signed [DATA_W-1:0]        elem;
    logic signed [DATA_W-1:0]        wr_val;
    int                              elem_addr;
    int                              out_idx;
    logic                            first_elem;
    logic                            scan_last;
    logic                            map_last;

    // ------------------------------------------------------------------------
    // Window addressing: element (win_r, win_c) of window (out_r, out_c).
    // ------------------------------------------------------------------------
    always_comb begin
        elem_addr  = (int'(out_r) * POOL + int'(win_r)) * IN_DIM
                   +  int'(out_c) * POOL + int'(win_c);
        out_idx    = int'(out_r) * OUT_DIM + int'(out_c);
        elem       = fm_buf[elem_addr*DATA_W +: DATA_W];
        first_elem = (win_r == '0) && (win_c == '0);
        scan_last  = (win_r == POOL_LAST) && (win_c == POOL_LAST);
        map_last   = (out_r == OUT_LAST) && (out_c == OUT_LAST);
    end

`ifdef POOL_RELU_EN
    assign wr_val = run_max[DATA_W-1] ? '0 : run_max;
`else
    assign wr_val = run_max;
`endif

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // ------------------------------------------------------------------------
    // FSM next-state and handshake outputs
    // ------------------------------------------------------------------------
    // NOTE: every output of this block is given a default first so that no
    // path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) next_state = S_LOAD;
            end
            S_LOAD:  next_state = S_SCAN;
            S_SCAN:  if (scan_last) next_state = S_WRITE;
            S_WRITE: next_state = map_last ? S_DONE : S_SCAN;
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: capture, window scan, result write-back
    // ------------------------------------------------------------------------
    // NOTE: the buffer and output map are flip-flop arrays, not RAM macros, so
    // they are cleared by reset like any other register; an aborted run must
    // leave output_fm all zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fm_buf    <= '0;
            output_fm <= '0;
            out_r     <= '0;
            out_c     <= '0;
            win_r     <= '0;
            win_c     <= '0;
            run_max   <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    fm_buf <= input_fm;
                    out_r  <= '0;
                    out_c  <= '0;
                    win_r  <= '0;
                    win_c  <= '0;
                end
                S_SCAN: begin
                    // Strict greater-than keeps the earlier element on ties.
                    if (first_elem || (elem > run_max)) run_max <= elem;
                    if (win_c == POOL_LAST) begin
                        win_c <= '0;
                        win_r <= (win_r == POOL_LAST) ? '0 : win_r + 1'b1;
                    end else begin
                        win_c <= win_c + 1'b1;
                    end
                end
                S_WRITE: begin
                    output_fm[out_idx*DATA_W +: DATA_W] <= wr_val;
                    win_r <= '0;
                    win_c <= '0;
                    if (!map_last) begin
                        if (out_c == OUT_LAST) begin
                            out_c <= '0;
                            out_r <= out_r + 1'b1;
                        end else begin
                            out_c <= out_c + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_max_pool_engine.sv
// ============================================================================
// tb_max_pool_engine
// ----------------------------------------------------------------------------
// Scoreboard bench for max_pool_engine. Each issued run pushes the expected
// pooled map and the expected done cycle; a negedge monitor pops and compares
// whenever done is seen. Honours POOL_RELU_EN the same way as the design.
// ============================================================================
module tb_max_pool_engine;

    localparam int DATA_W   = 32;
    localparam int IN_DIM   = 6;
    localparam int POOL     = 2;
    localparam int OUT_DIM  = IN_DIM / POOL;
    localparam int IN_BITS  = IN_DIM * IN_DIM * DATA_W;
    localparam int OUT_BITS = OUT_DIM * OUT_DIM * DATA_W;
    localparam int LATENCY  = 1 + OUT_DIM * OUT_DIM * (POOL * POOL + 1);

    typedef logic [IN_BITS-1:0]  in_map_t;
    typedef logic [OUT_BITS-1:0] out_map_t;

    typedef struct {
        out_map_t map;
        int       done_cyc;
    } exp_t;

    logic     clk = 1'b0;
    logic     rst = 1'b0;
    logic     start = 1'b0;
    in_map_t  input_fm = '0;
    logic     busy;
    logic     done;
    out_map_t output_fm;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    max_pool_engine #(
        .DATA_W(DATA_W),
        .IN_DIM(IN_DIM),
        .POOL  (POOL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .input_fm (input_fm),
        .busy     (busy),
        .done     (done),
        .output_fm(output_fm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- helpers
    task automatic check(input string name, input out_map_t got, input out_map_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: maximum over each POOL x POOL window, straight from the rules.
    function automatic out_map_t pool_model(input in_map_t fm);
        out_map_t res;
        logic signed [DATA_W-1:0] best, v;
        res = '0;
        for (int r = 0; r < OUT_DIM; r++) begin
            for (int c = 0; c < OUT_DIM; c++) begin
                best = fm[((POOL*r)*IN_DIM + POOL*c)*DATA_W +: DATA_W];
                for (int dr = 0; dr < POOL; dr++) begin
                    for (int dc = 0; dc < POOL; dc++) begin
                        v = fm[((POOL*r+dr)*IN_DIM + POOL*c+dc)*DATA_W +: DATA_W];
                        if (v > best) best = v;
                    end
                end
`ifdef POOL_RELU_EN
                if (best < 0) best = '0;
`endif
                res[(r*OUT_DIM+c)*DATA_W +: DATA_W] = best;
            end
        end
        return res;
    endfunction

    function automatic in_map_t make_asc();
        in_map_t m;
        for (int i = 0; i < IN_DIM*IN_DIM; i++) m[i*DATA_W +: DATA_W] = DATA_W'(i);
        return m;
    endfunction

    function automatic in_map_t make_neg();
        in_map_t m;
        for (int i = 0; i < IN_DIM*IN_DIM; i++) m[i*DATA_W +: DATA_W] = DATA_W'(-(i+1));
        return m;
    endfunction

    function automatic in_map_t make_const(input int v);
        in_map_t m;
        for (int i = 0; i < IN_DIM*IN_DIM; i++) m[i*DATA_W +: DATA_W] = DATA_W'(v);
        return m;
    endfunction

    // Mix of full-range values, a narrow band (many ties) and extremes.
    function automatic in_map_t make_rand();
        in_map_t m;
        logic [DATA_W-1:0] v;
        for (int i = 0; i < IN_DIM*IN_DIM; i++) begin
            case ($urandom_range(0, 2))
                0:       v = $urandom;
                1:       v = DATA_W'(int'($urandom_range(0, 6)) - 3);
                default: begin
                    case ($urandom_range(0, 3))
                        0:       v = 32'h8000_0000;
                        1:       v = 32'h7fff_ffff;
                        2:       v = 32'h0000_0000;
                        default: v = 32'hffff_ffff;
                    endcase
                end
            endcase
            m[i*DATA_W +: DATA_W] = v;
        end
        return m;
    endfunction

    function automatic out_map_t pack_out(input int vals [OUT_DIM*OUT_DIM]);
        out_map_t m;
        for (int i = 0; i < OUT_DIM*OUT_DIM; i++) m[i*DATA_W +: DATA_W] = DATA_W'(vals[i]);
        return m;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives map and start for one edge (E0); returns after E0 with start low.
    task automatic issue_run(input in_map_t m, output int e0);
        exp_t e;
        input_fm = m;
        start    = 1'b1;
        e0       = cyc + 1;
        e.map      = pool_model(m);
        e.done_cyc = e0 + LATENCY;
        sb.push_back(e);
        tick(1);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_pending", out_map_t'(sb.size()), '0);
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending run", cyc);
            end else begin
                e = sb.pop_front();
                check("output_map", output_fm, e.map);
                check("done_cycle", out_map_t'(cyc), out_map_t'(e.done_cyc));
                check("busy_in_done", out_map_t'(busy), out_map_t'(1));
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    initial begin : stim
        int e0;
        int asc_vals [OUT_DIM*OUT_DIM];
        int neg_vals [OUT_DIM*OUT_DIM];
        in_map_t ma, mb, mc;

        asc_vals = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
`ifdef POOL_RELU_EN
        neg_vals = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
        neg_vals = '{-1, -3, -5, -13, -15, -17, -25, -27, -29};
`endif

        // Reset state
        input_fm = make_rand();
        tick(3);
        check("reset_busy", out_map_t'(busy), '0);
        check("reset_done", out_map_t'(done), '0);
        check("reset_output", output_fm, '0);
        rst = 1'b1;
        tick(2);

        // Ascending map: latency, result, busy falls with done
        issue_run(make_asc(), e0);
        drain();
        check("asc_output_const", output_fm, pack_out(asc_vals));
        check("asc_busy_after_done", out_map_t'(busy), '0);
        check("asc_done_after", out_map_t'(done), '0);
        tick(2);

        // All-negative map
        issue_run(make_neg(), e0);
        drain();
        check("neg_output_const", output_fm, pack_out(neg_vals));
        tick(1);

        // Input changed right after the LOAD edge must not affect the result
        issue_run(make_asc(), e0);
        tick(1);
        input_fm = make_const(1000);
        drain();
        tick(1);

        // Start held high: three back-to-back runs, map swapped after each LOAD
        begin
            exp_t e;
            ma = make_rand();
            mb = make_rand();
            mc = make_rand();
            input_fm = ma;
            start    = 1'b1;
            e0       = cyc + 1;
            e.map = pool_model(ma); e.done_cyc = e0 + LATENCY;      sb.push_back(e);
            tick(2);                                                // after LOAD edge E0+1
            input_fm = mb;
            e.map = pool_model(mb); e.done_cyc = e0 + 48 + LATENCY; sb.push_back(e);
            tick(48);                                               // after E0+49
            input_fm = mc;
            e.map = pool_model(mc); e.done_cyc = e0 + 96 + LATENCY; sb.push_back(e);
            tick(48);                                               // after E0+97
            start    = 1'b0;
            input_fm = make_rand();
            drain();
            tick(2);
        end

        // Start toggled while running: ignored, busy held until done
        issue_run(make_rand(), e0);
        for (int k = 0; k < 40; k++) begin
            start = 1'($urandom_range(0, 1));
            check("busy_while_running", out_map_t'(busy), out_map_t'(1));
            tick(1);
        end
        start = 1'b0;
        drain();
        tick(60);   // any spurious extra done is flagged by the monitor

        // Reset mid-run: abort, clear, no done, then a clean run
        issue_run(make_rand(), e0);
        tick(20);   // just after edge E0+20
        rst = 1'b0;
        sb.delete();
        #1;
        check("midreset_busy", out_map_t'(busy), '0);
        check("midreset_output", output_fm, '0);
        tick(2);
        rst = 1'b1;
        tick(60);
        check("postreset_busy", out_map_t'(busy), '0);
        check("postreset_output", output_fm, '0);
        issue_run(make_asc(), e0);
        drain();
        check("postreset_asc_const", output_fm, pack_out(asc_vals));
        tick(1);

        // Randomised runs with random idle gaps
        for (int n = 0; n < 10; n++) begin
            issue_run(make_rand(), e0);
            drain();
            tick($urandom_range(1, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
